// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Imported by the fetch interface, skid buffer and fetch_stage top.
package fetch_stage_pkg;

  localparam int unsigned FETCH_AW = 32;
  localparam int unsigned FETCH_DW = 32;

  localparam logic [FETCH_AW-1:0] BASEADDR_DEF = 32'h0100_0000;
  localparam logic [FETCH_DW-1:0] NOP_INSN     = 32'h0000_0013;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] insn;
  } fetch_entry_t;

  function automatic logic [6:0] insn_opcode(
    input logic [FETCH_DW-1:0] insn
  );
    return insn[6:0];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch bus bundle: instruction-memory request/response plus
// the valid/ready handshake towards decode.
interface fetch_stage_if
  import fetch_stage_pkg::*;
#(
  parameter int unsigned AWIDTH = FETCH_AW,
  parameter int unsigned DWIDTH = FETCH_DW
) ();

  logic              imem_req_o;
  logic [AWIDTH-1:0] imem_addr_o;
  logic [DWIDTH-1:0] imem_rdata_i;
  logic              ready_i;
  logic              valid_o;
  logic [AWIDTH-1:0] pc_o;
  logic [DWIDTH-1:0] insn_o;
  logic [6:0]        opcode_o;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_rdata_i,
    input  ready_i,
    output valid_o,
    output pc_o,
    output insn_o,
    output opcode_o
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_rdata_i,
    output ready_i,
    input  valid_o,
    input  pc_o,
    input  insn_o,
    input  opcode_o
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of fetched {pc, insn} with push/pop/flush.
// Flush wins over push and pop in the same cycle.
module fetch_skid_buf
  import fetch_stage_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       push_i,
  input  entry_t     data_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output entry_t     head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [1:0] count_o
);

  entry_t     mem_q [2];
  logic       rd_q;
  logic       rd_d;
  logic       wr_q;
  logic       wr_d;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic       do_push;
  logic       do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (cnt_q != 2'd0);

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  // Pointer and occupancy next-state.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = 1'b0;
      wr_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (do_pop)  rd_d = ~rd_q;
      if (do_push) wr_d = ~wr_q;
      cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Pointer and occupancy registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are only read when non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  no_overflow_a: assert property (
    @(posedge clk) disable iff (!rst_ni)
    !(do_push && full_o && !do_pop)
  );

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC owner, imem requester, decode feeder.
// Optional misaligned-redirect trap: define FETCH_MISALIGN_TRAP_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned       AWIDTH   = FETCH_AW,
  parameter int unsigned       DWIDTH   = FETCH_DW,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(BASEADDR_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  fetch_stage_if.master     bus,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic              misalign_o
`endif
);

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } entry_t;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [AWIDTH-1:0] pc_q;
  logic [AWIDTH-1:0] pc_d;
  logic              infl_q;
  logic              infl_d;
  logic [AWIDTH-1:0] infl_pc_q;
  logic [AWIDTH-1:0] infl_pc_d;
  logic [AWIDTH-1:0] last_pc_q;
  logic [AWIDTH-1:0] last_pc_d;
  logic              mis_q;
  logic              mis_d;

  logic [AWIDTH-1:0] redir_tgt;
  logic              redir_bad;
  logic              running;
  logic              out_valid;
  logic              pop;
  logic              push;
  logic              req;
  logic [2:0]        occ;
  logic [DWIDTH-1:0] insn_w;

  entry_t            push_data;
  entry_t            buf_head;
  logic              buf_full;
  logic              buf_empty;
  logic [1:0]        buf_count;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_tgt  = redirect_pc_i;
  assign redir_bad  = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign misalign_o = mis_q;
`else
  assign redir_tgt  = redirect_pc_i & ~AWIDTH'(3);
  assign redir_bad  = 1'b0;
`endif

  assign running   = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign out_valid = !buf_empty && !mis_q;
  assign pop       = out_valid && bus.ready_i;

  // Slots claimed after this edge: buffered + arriving - leaving.
  assign occ = {1'b0, buf_count} + {2'b00, infl_q} - {2'b00, pop};
  assign req = running && !redirect_i && !mis_q && (occ < 3'd2);

  // The arriving word is dropped when a redirect lands on this edge.
  assign push      = infl_q && !redirect_i;
  assign push_data = '{pc: infl_pc_q, insn: bus.imem_rdata_i};

  fetch_skid_buf #(
    .entry_t (entry_t)
  ) u_buf (
    .clk     (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .head_o  (buf_head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  assign insn_w = buf_empty ? DWIDTH'(NOP_INSN) : buf_head.insn;

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = pc_q;
  assign bus.valid_o     = out_valid;
  assign bus.pc_o        = buf_empty ? last_pc_q : buf_head.pc;
  assign bus.insn_o      = insn_w;
  assign bus.opcode_o    = insn_opcode(insn_w);

  // FSM: idle one cycle after reset, flush one cycle after redirect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = redirect_i ? S_FLUSH : S_RUN;
      S_RUN:   state_d = redirect_i ? S_FLUSH : S_RUN;
      S_FLUSH: state_d = redirect_i ? S_FLUSH : S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // PC, in-flight tracking, last presented PC, trap flag.
  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      redirect_i: pc_d = redir_tgt;
      req:        pc_d = pc_q + AWIDTH'(4);
      default:    pc_d = pc_q;
    endcase
    infl_d    = req;
    infl_pc_d = pc_q;
    last_pc_d = buf_empty ? last_pc_q : buf_head.pc;
    mis_d     = mis_q || redir_bad;
  end

  // Fetch state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= BASEADDR;
      infl_q    <= 1'b0;
      infl_pc_q <= BASEADDR;
      last_pc_q <= BASEADDR;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
      last_pc_q <= last_pc_d;
      mis_q     <= mis_d;
    end
  end

  buf_no_overflow_a: assert property (
    @(posedge clk) disable iff (!reset)
    !(buf_full && push && !pop)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based stream model.
// Build with or without FETCH_MISALIGN_TRAP_EN.
module tb_fetch_stage;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int checks = 0;
  int errors = 0;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_o    (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a ^ 32'h5A5A_A5A5) + {a[15:0], a[31:16]};
  endfunction

  always @(posedge clk) begin
    if (bus.imem_req_o) bus.imem_rdata_i <= memw(bus.imem_addr_o);
    else                bus.imem_rdata_i <= $urandom;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the buffer is a queue of PCs, plus one in-flight PC.
  bit          started = 0;
  bit          m_run;
  bit          m_mis;
  bit          m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_pc;
  logic [31:0] m_last;
  logic [31:0] m_q[$];

  function automatic bit m_pop();
    return (m_q.size() > 0) && !m_mis && (bus.ready_i === 1'b1);
  endfunction

  function automatic bit m_req();
    int occ;
    occ = m_q.size() + int'(m_infl) - int'(m_pop());
    return m_run && !redirect_i && !m_mis && (occ < 2);
  endfunction

  always @(posedge clk) begin
    bit rq;
    bit pp;
    if (!reset) begin
      started = 1;
      m_run   = 0;
      m_mis   = 0;
      m_infl  = 0;
      m_pc    = BASE;
      m_last  = BASE;
      m_q.delete();
    end else begin
      rq = m_req();
      pp = m_pop();
      if (m_q.size() > 0) m_last = m_q[0];
      if (redirect_i) begin
        m_q.delete();
        m_infl = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (redirect_pc_i[1:0] != 2'b00) m_mis = 1;
        m_pc = redirect_pc_i;
`else
        m_pc = redirect_pc_i & ~32'h3;
`endif
      end else begin
        if (pp) void'(m_q.pop_front());
        if (m_infl) m_q.push_back(m_infl_pc);
        m_infl    = rq;
        m_infl_pc = m_pc;
        if (rq) m_pc = m_pc + 32'd4;
      end
      m_run = 1;
    end
  end

  always @(negedge clk) begin
    bit ev;
    bit er;
    if (started) begin
      ev = (m_q.size() > 0) && !m_mis;
      er = m_req();
      chk("valid", {31'b0, bus.valid_o}, {31'b0, ev});
      if (m_q.size() > 0) begin
        chk("pc", bus.pc_o, m_q[0]);
        chk("insn", bus.insn_o, memw(m_q[0]));
        chk("opcode", {25'b0, bus.opcode_o}, {25'b0, memw(m_q[0]) & 32'h7F});
      end else begin
        chk("pc_idle", bus.pc_o, m_last);
        chk("insn_nop", bus.insn_o, NOP);
        chk("opcode_nop", {25'b0, bus.opcode_o}, 32'h13);
      end
      chk("req", {31'b0, bus.imem_req_o}, {31'b0, er});
      if (er) chk("addr", bus.imem_addr_o, m_pc);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("misalign", {31'b0, misalign_o}, {31'b0, m_mis});
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] t);
    redirect_i    = 1'b1;
    redirect_pc_i = t;
    tick();
    redirect_i    = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    bus.ready_i   = 1'b1;
    repeat (3) tick();
    chk("rst_valid", {31'b0, bus.valid_o}, 32'd0);
    chk("rst_req", {31'b0, bus.imem_req_o}, 32'd0);
    chk("rst_pc", bus.pc_o, BASE);
    chk("rst_insn", bus.insn_o, NOP);
    chk("rst_opcode", {25'b0, bus.opcode_o}, 32'h13);

    reset = 1'b1;
    tick();
    chk("t1_req", {31'b0, bus.imem_req_o}, 32'd1);
    chk("t1_addr", bus.imem_addr_o, BASE);
    tick();
    chk("t1_v0", {31'b0, bus.valid_o}, 32'd0);
    tick();
    chk("t1_v1", {31'b0, bus.valid_o}, 32'd1);
    chk("t1_pc0", bus.pc_o, BASE);
    tick();
    chk("t1_pc1", bus.pc_o, 32'h0100_0004);
    tick();
    chk("t1_pc2", bus.pc_o, 32'h0100_0008);

    bus.ready_i = 1'b0;
    repeat (5) tick();
    chk("t2_hold", bus.pc_o, 32'h0100_0008);
    chk("t2_noreq", {31'b0, bus.imem_req_o}, 32'd0);
    bus.ready_i = 1'b1;
    tick();
    chk("t2_pc3", bus.pc_o, 32'h0100_000C);
    tick();
    chk("t2_pc4", bus.pc_o, 32'h0100_0010);

    bus.ready_i = 1'b0;
    repeat (3) tick();
    redir(32'h0100_0040);
    chk("t3_v0", {31'b0, bus.valid_o}, 32'd0);
    chk("t3_addr", bus.imem_addr_o, 32'h0100_0040);
    tick();
    chk("t3_v1", {31'b0, bus.valid_o}, 32'd0);
    tick();
    chk("t3_pc", bus.pc_o, 32'h0100_0040);
    bus.ready_i = 1'b1;

    repeat (2) tick();
    redir(32'h0100_0200);
    chk("t4_v0", {31'b0, bus.valid_o}, 32'd0);
    tick();
    chk("t4_v1", {31'b0, bus.valid_o}, 32'd0);
    tick();
    chk("t4_pc", bus.pc_o, 32'h0100_0200);
    tick();
    chk("t4_pc1", bus.pc_o, 32'h0100_0204);

    reset = 1'b0;
    tick();
    reset = 1'b1;
    redir(32'h0100_0300);
    chk("t4_idle_addr", bus.imem_addr_o, 32'h0100_0300);
    repeat (2) tick();
    chk("t4_idle_pc", bus.pc_o, 32'h0100_0300);

    redir(32'hFFFF_FFFC);
    chk("t5_addr0", bus.imem_addr_o, 32'hFFFF_FFFC);
    tick();
    chk("t5_wrap", bus.imem_addr_o, 32'h0000_0000);
    tick();
    chk("t5_pc0", bus.pc_o, 32'hFFFF_FFFC);
    tick();
    chk("t5_pc1", bus.pc_o, 32'h0000_0000);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      bus.ready_i = ($urandom_range(9) < 7);
      redirect_i  = ($urandom_range(19) == 0);
      reset       = ($urandom_range(99) != 0);
      if ($urandom_range(3) == 0) t = $urandom;
      else t = BASE + 32'($urandom_range(255)) * 4;
`ifdef FETCH_MISALIGN_TRAP_EN
      t[1:0] = 2'b00;
`else
      t[1:0] = 2'($urandom_range(3));
`endif
      redirect_pc_i = t;
      tick();
    end
    redirect_i  = 1'b0;
    reset       = 1'b1;
    bus.ready_i = 1'b1;
    repeat (4) tick();

    redir(32'h0100_0042);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("t6_mis", {31'b0, misalign_o}, 32'd1);
    repeat (2) tick();
    chk("t6_v", {31'b0, bus.valid_o}, 32'd0);
    chk("t6_noreq", {31'b0, bus.imem_req_o}, 32'd0);
    chk("t6_sticky", {31'b0, misalign_o}, 32'd1);
    reset = 1'b0;
    tick();
    chk("t6_clr", {31'b0, misalign_o}, 32'd0);
    reset = 1'b1;
`else
    chk("t6_addr", bus.imem_addr_o, 32'h0100_0040);
    repeat (2) tick();
    chk("t6_v", {31'b0, bus.valid_o}, 32'd1);
    chk("t6_pc", bus.pc_o, 32'h0100_0040);
`endif
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
